// File: rtl/seq_pkg.sv
// Shared definitions for prog_sequencer: FSM states, program numbers,
// and the per-program data-memory layout (operand/result bases and sizes).
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_READ  = 3'd4,
    S_RESP  = 3'd5
  } seq_state_e;

  // Program numbers carried on req_prog; 0 is never a valid program.
  localparam logic [1:0] PROG_NONE  = 2'd0;
  localparam logic [1:0] PROG_RECIP = 2'd1;
  localparam logic [1:0] PROG_DIV   = 2'd2;
  localparam logic [1:0] PROG_SQRT  = 2'd3;

  // Data-memory layout, big-endian: high byte sits at the lower address.
  localparam logic [7:0] RECIP_OP_BASE  = 8'd8;
  localparam logic [7:0] RECIP_RES_BASE = 8'd10;
  localparam logic [1:0] RECIP_OP_N     = 2'd2;
  localparam logic [1:0] RECIP_RES_N    = 2'd2;

  localparam logic [7:0] DIV_OP_BASE    = 8'd0;
  localparam logic [7:0] DIV_RES_BASE   = 8'd4;
  localparam logic [1:0] DIV_OP_N       = 2'd3;
  localparam logic [1:0] DIV_RES_N      = 2'd3;

  localparam logic [7:0] SQRT_OP_BASE   = 8'd16;
  localparam logic [7:0] SQRT_RES_BASE  = 8'd18;
  localparam logic [1:0] SQRT_OP_N      = 2'd2;
  localparam logic [1:0] SQRT_RES_N     = 2'd1;

  function automatic logic [7:0] op_base(input logic [1:0] prog);
    case (prog)
      PROG_DIV:  op_base = DIV_OP_BASE;
      PROG_SQRT: op_base = SQRT_OP_BASE;
      default:   op_base = RECIP_OP_BASE;
    endcase
  endfunction

  function automatic logic [1:0] op_count(input logic [1:0] prog);
    case (prog)
      PROG_DIV:  op_count = DIV_OP_N;
      PROG_SQRT: op_count = SQRT_OP_N;
      default:   op_count = RECIP_OP_N;
    endcase
  endfunction

  function automatic logic [7:0] res_base(input logic [1:0] prog);
    case (prog)
      PROG_DIV:  res_base = DIV_RES_BASE;
      PROG_SQRT: res_base = SQRT_RES_BASE;
      default:   res_base = RECIP_RES_BASE;
    endcase
  endfunction

  function automatic logic [1:0] res_count(input logic [1:0] prog);
    case (prog)
      PROG_DIV:  res_count = DIV_RES_N;
      PROG_SQRT: res_count = SQRT_RES_N;
      default:   res_count = RECIP_RES_N;
    endcase
  endfunction

  // Operand byte written at index idx (0 = lowest address = most significant).
  function automatic logic [7:0] operand_byte(input logic [1:0]  prog,
                                              input logic [23:0] operand,
                                              input logic [1:0]  idx);
    if (prog == PROG_DIV) begin
      case (idx)
        2'd0:    operand_byte = operand[23:16];
        2'd1:    operand_byte = operand[15:8];
        default: operand_byte = operand[7:0];
      endcase
    end else begin
      operand_byte = (idx == 2'd0) ? operand[15:8] : operand[7:0];
    end
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter used as the RUN watchdog. 'expired' is high while
// the count is zero; loading takes priority over counting.
module seq_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  // Count down towards zero and stick there until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs one CPU program for a single requester. Loads the
// operand into data memory, pulses cpu_start, waits for a fresh cpu_ack,
// reads the result back and returns it on a valid/ready response.
// Optional feature macro: SEQ_TIMEOUT_EN (RUN watchdog, aborts after TIMEOUT
// cycles with rsp_err=1). Without it RUN waits indefinitely.
//
// Handshakes: a request transfers on a rising Clk edge where req_valid and
// req_ready are both 1; a response transfers where rsp_valid and rsp_ready are
// both 1. rsp_result/rsp_err are held stable while rsp_valid waits for ready.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4096
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_prog,
  input  logic [23:0] req_operand,
  output logic        mem_own,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_start,
  input  logic        cpu_ack,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_result,
  output logic        rsp_err,
  output logic [2:0]  dbg_state
);

  seq_state_e  state, state_d;
  logic [15:0] cnt;           // cycle index within WRITE / START / READ
  logic [1:0]  prog_q;
  logic [23:0] operand_q;
  logic [23:0] result_q;
  logic        err_q;
  logic        ack_low_seen;  // cpu_ack seen low since START was entered
  logic        ack_qual;
  logic        run_timeout;
  logic        timer_expired;

  // A stale Ack left high by the previous run must not finish this one.
  assign ack_qual = cpu_ack && ack_low_seen;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;

  seq_timer #(
    .W (TW)
  ) u_timer (
    .clk        (Clk),
    .rst_n      (Reset),
    .load       (state == S_START),
    .load_value (TW'(TIMEOUT - 1)),
    .en         (state == S_RUN),
    .expired    (timer_expired)
  );
`else
  // No watchdog: RUN never times out.
  assign timer_expired = 1'b0;
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_d     = state;
    req_ready   = 1'b0;
    mem_own     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 8'd0;
    mem_wdata   = 8'd0;
    cpu_start   = 1'b0;
    rsp_valid   = 1'b0;
    run_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_prog == PROG_NONE) ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        mem_own   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = op_base(prog_q) + cnt[7:0];
        mem_wdata = operand_byte(prog_q, operand_q, cnt[1:0]);
        if (cnt == {14'd0, op_count(prog_q)} - 16'd1) state_d = S_START;
      end
      S_START: begin
        cpu_start = 1'b1;
        if (cnt == 16'(START_CYCLES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (ack_qual) begin
          state_d = S_READ;
        end else if (timer_expired) begin
          state_d     = S_RESP;
          run_timeout = 1'b1;
        end
      end
      S_READ: begin
        mem_own = 1'b1;
        if (cnt < {14'd0, res_count(prog_q)}) mem_addr = res_base(prog_q) + cnt[7:0];
        if (cnt == {14'd0, res_count(prog_q)}) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, per-state cycle index, result assembly and Ack qualifier.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt          <= 16'd0;
      prog_q       <= PROG_NONE;
      operand_q    <= 24'd0;
      result_q     <= 24'd0;
      err_q        <= 1'b0;
      ack_low_seen <= 1'b0;
    end else begin
      cnt <= (state_d != state) ? 16'd0 : cnt + 16'd1;
      if (state == S_IDLE && req_valid) begin
        prog_q    <= req_prog;
        operand_q <= req_operand;
        result_q  <= 24'd0;
        err_q     <= (req_prog == PROG_NONE);
      end
      // Read data lags its address by one cycle; shifting in high byte first
      // leaves the unused upper bits zero.
      if (state == S_READ && cnt != 16'd0) result_q <= {result_q[15:0], mem_rdata};
      if (run_timeout) begin
        err_q    <= 1'b1;
        result_q <= 24'd0;
      end
      if (state != S_START && state_d == S_START) ack_low_seen <= 1'b0;
      else if ((state == S_START || state == S_RUN) && !cpu_ack) ack_low_seen <= 1'b1;
    end
  end

  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a behavioural DM and CPU model.
module tb_prog_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_prog;
  logic [23:0] req_operand;
  logic        mem_own, mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        cpu_start, cpu_ack;
  logic        rsp_valid, rsp_ready;
  logic [23:0] rsp_result;
  logic        rsp_err;
  logic [2:0]  dbg_state;

  // CPU-side DM write port (used while the sequencer does not own DM)
  logic        cpu_we;
  logic [7:0]  cpu_addr, cpu_wdata;

  logic [7:0]  dm [256];
  logic [15:0] wr_log [64];
  int          n_wr = 0, n_rd = 0, n_start = 0, cyc = 0;

  logic [15:0] exp_q [$];
  int          checks = 0, passed = 0;

  prog_sequencer #(.START_CYCLES(2), .TIMEOUT(64)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_prog(req_prog), .req_operand(req_operand),
    .mem_own(mem_own), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_start(cpu_start), .cpu_ack(cpu_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 Clk = ~Clk;

  // DM with external ownership mux, plus activity monitors
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (mem_own) begin
      if (mem_we) begin
        dm[mem_addr]        <= mem_wdata;
        wr_log[n_wr % 64]   <= {mem_addr, mem_wdata};
        n_wr                <= n_wr + 1;
      end else begin
        n_rd <= n_rd + 1;
      end
      mem_rdata <= dm[mem_addr];
    end else if (cpu_we) begin
      dm[cpu_addr] <= cpu_wdata;
    end
    if (cpu_start) n_start <= n_start + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Driver: raise a request at a negedge; returns at the negedge after the handshake.
  task automatic send_req(input logic [1:0] prog, input logic [23:0] op, output int hs);
    @(negedge Clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_prog = prog; req_operand = op;
    @(negedge Clk);
    hs = cyc;
    req_valid = 1'b0; req_prog = 2'd0; req_operand = 24'd0;
  endtask

  // Wait for the cpu_start pulse and measure it; returns at RUN cycle 1.
  task automatic wait_start(output int width);
    int n = 0;
    width = 0;
    while (!cpu_start && n < 40) begin @(negedge Clk); n++; end
    while (cpu_start && width < 40) begin @(negedge Clk); width++; end
  endtask

  // CPU model: write nres result bytes from RUN cycle 1, raise Ack in RUN cycle d.
  task automatic cpu_finish(input int d, input logic [7:0] base,
                            input logic [23:0] res, input int nres);
    for (int i = 0; i < nres; i++) begin
      cpu_we = 1'b1; cpu_addr = base + 8'(i);
      cpu_wdata = 8'(res >> (8 * (nres - 1 - i)));
      @(negedge Clk);
    end
    cpu_we = 1'b0;
    repeat (d - 1 - nres) @(negedge Clk);
    cpu_ack = 1'b1;
  endtask

  task automatic wait_rsp(input int hs, output int lat);
    int n = 0;
    while (!rsp_valid && n < 400) begin @(negedge Clk); n++; end
    lat = cyc - hs;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
    chk("idle_after_rsp", dbg_state, 0);
    chk("req_ready_after_rsp", req_ready, 1);
    chk("rsp_valid_after_rsp", rsp_valid, 0);
  endtask

  // Scoreboard: compare logged DM writes since wr0 against exp_q
  task automatic check_writes(input int wr0);
    chk("wr_count", n_wr - wr0, exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      chk("wr_entry", wr_log[(wr0 + i) % 64], e);
    end
  endtask

  initial begin
    int hs, lat, w, wr0, rd0, st0;
    Reset = 1'b0; req_valid = 1'b0; req_prog = 2'd0; req_operand = 24'd0;
    cpu_ack = 1'b0; rsp_ready = 1'b0; cpu_we = 1'b0; cpu_addr = 8'd0; cpu_wdata = 8'd0;
    repeat (3) @(negedge Clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_own", mem_own, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_start", cpu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_state", dbg_state, 0);
    Reset = 1'b1;

    // P1 reciprocal, operand 400, Ack in RUN cycle 50, result 0x0051
    wr0 = n_wr; rd0 = n_rd;
    exp_q.push_back({8'd8, 8'h01}); exp_q.push_back({8'd9, 8'h90});
    send_req(2'd1, 24'h000190, hs);
    wait_start(w);
    chk("p1_start_width", w, 2);
    chk("p1_state_run", dbg_state, 3);
    cpu_finish(50, 8'd10, 24'h000051, 2);
    wait_rsp(hs, lat);
    chk("p1_latency", lat, 57);
    chk("p1_result", rsp_result, 24'h000051);
    chk("p1_err", rsp_err, 0);
    chk("p1_read_cycles", n_rd - rd0, 3);
    check_writes(wr0);
    release_rsp();
    cpu_ack = 1'b0;

    // P3 square root, operand 0x0100, result 0x10
    wr0 = n_wr; rd0 = n_rd;
    exp_q.push_back({8'd16, 8'h01}); exp_q.push_back({8'd17, 8'h00});
    send_req(2'd3, 24'h000100, hs);
    wait_start(w);
    chk("p3_start_width", w, 2);
    cpu_finish(10, 8'd18, 24'h000010, 1);
    wait_rsp(hs, lat);
    chk("p3_latency", lat, 16);
    chk("p3_result", rsp_result, 24'h000010);
    chk("p3_err", rsp_err, 0);
    chk("p3_read_cycles", n_rd - rd0, 2);
    check_writes(wr0);
    release_rsp();
    cpu_ack = 1'b0;

    // P2 divide 1000/7, result bytes 00 8E 06; Ack left high afterwards
    wr0 = n_wr; rd0 = n_rd;
    exp_q.push_back({8'd0, 8'h03}); exp_q.push_back({8'd1, 8'hE8});
    exp_q.push_back({8'd2, 8'h07});
    send_req(2'd2, 24'h03E807, hs);
    wait_start(w);
    chk("p2_start_width", w, 2);
    cpu_finish(8, 8'd4, 24'h008E06, 3);
    wait_rsp(hs, lat);
    chk("p2_latency", lat, 17);
    chk("p2_result", rsp_result, 24'h008E06);
    chk("p2_read_cycles", n_rd - rd0, 4);
    check_writes(wr0);
    release_rsp();

    // Invalid program: response in the cycle after the handshake, no DM/CPU activity
    wr0 = n_wr; st0 = n_start;
    send_req(2'd0, 24'h123456, hs);
    chk("inv_rsp_valid", rsp_valid, 1);
    chk("inv_rsp_err", rsp_err, 1);
    chk("inv_rsp_result", rsp_result, 0);
    release_rsp();
    chk("inv_no_writes", n_wr - wr0, 0);
    chk("inv_no_start", n_start - st0, 0);

    // Stale Ack: high from the P2 run, dropped in RUN cycle 6, raised in cycle 26
    wr0 = n_wr;
    exp_q.push_back({8'd8, 8'h00}); exp_q.push_back({8'd9, 8'h02});
    send_req(2'd1, 24'h000002, hs);
    wait_start(w);
    chk("stale_start_width", w, 2);
    repeat (5) @(negedge Clk);
    chk("stale_ignored_state", dbg_state, 3);
    chk("stale_ignored_valid", rsp_valid, 0);
    cpu_ack = 1'b0;
    cpu_we = 1'b1; cpu_addr = 8'd10; cpu_wdata = 8'h80;
    @(negedge Clk);
    cpu_addr = 8'd11; cpu_wdata = 8'h00;
    @(negedge Clk);
    cpu_we = 1'b0;
    repeat (18) @(negedge Clk);
    cpu_ack = 1'b1;
    wait_rsp(hs, lat);
    chk("stale_latency", lat, 33);
    chk("stale_result", rsp_result, 24'h008000);
    check_writes(wr0);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("hold_result", rsp_result, 24'h008000);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
    end
    release_rsp();
    cpu_ack = 1'b0;

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: CPU never acks, abort after 64 RUN cycles without READ
    rd0 = n_rd;
    send_req(2'd1, 24'h000003, hs);
    wait_start(w);
    wait_rsp(hs, lat);
    chk("to_latency", lat, 68);
    chk("to_err", rsp_err, 1);
    chk("to_result", rsp_result, 0);
    chk("to_no_read", n_rd - rd0, 0);
    release_rsp();
`endif

    // Reset during WRITE drops mem_we/mem_own at once
    send_req(2'd2, 24'h111111, hs);
    chk("wr_mem_we_before", mem_we, 1);
    Reset = 1'b0;
    #1;
    chk("rst_wr_mem_we", mem_we, 0);
    chk("rst_wr_mem_own", mem_own, 0);
    chk("rst_wr_state", dbg_state, 0);
    @(negedge Clk);
    Reset = 1'b1;

    // Reset during START drops cpu_start at once
    send_req(2'd3, 24'h000004, hs);
    for (int n = 0; n < 10 && !cpu_start; n++) @(negedge Clk);
    chk("start_seen", cpu_start, 1);
    Reset = 1'b0;
    #1;
    chk("rst_st_cpu_start", cpu_start, 0);
    chk("rst_st_state", dbg_state, 0);
    @(negedge Clk);
    Reset = 1'b1;

    // Reset during RUN returns to IDLE
    send_req(2'd1, 24'h000005, hs);
    wait_start(w);
    repeat (3) @(negedge Clk);
    chk("run_before_reset", dbg_state, 3);
    Reset = 1'b0;
    #1;
    chk("rst_run_cpu_start", cpu_start, 0);
    chk("rst_run_mem_own", mem_own, 0);
    chk("rst_run_mem_we", mem_we, 0);
    chk("rst_run_state", dbg_state, 0);
    chk("rst_run_req_ready", req_ready, 1);
    @(negedge Clk);
    Reset = 1'b1;

    // Following P1 request completes normally
    wr0 = n_wr;
    exp_q.push_back({8'd8, 8'h01}); exp_q.push_back({8'd9, 8'h00});
    send_req(2'd1, 24'h000100, hs);
    wait_start(w);
    chk("post_start_width", w, 2);
    cpu_finish(12, 8'd10, 24'h001234, 2);
    wait_rsp(hs, lat);
    chk("post_latency", lat, 19);
    chk("post_result", rsp_result, 24'h001234);
    chk("post_err", rsp_err, 0);
    check_writes(wr0);
    release_rsp();
    cpu_ack = 1'b0;

    // Final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
